// File: rtl/reg_file_pkg.sv
// ============================================================================
// reg_file_pkg : shared clear-FSM state type and default register-file sizes.
// Revision: 1.0
// ============================================================================
`default_nettype none

package reg_file_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } clr_state_e;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int NUM_RD_DEF = 2;

endpackage

`default_nettype wire

// File: rtl/reg_file_clear_seq.sv
// ============================================================================
// reg_file_clear_seq : sweeps a zero write across every entry, one per cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_file_clear_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              sweep_en,
    output logic [ADDR_W-1:0] sweep_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    clr_state_e        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;
    logic              done_q;

    // done_q is raised one edge early so it coincides with the final sweep write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_q <= SWEEP;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= (LAST_ADDR == '0);
                    end
                end
                SWEEP: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + ADDR_W'(1);
                        done_q  <= ((cnt_q + ADDR_W'(1)) == LAST_ADDR);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_busy   = busy_q;
    assign clr_done   = done_q;
    assign sweep_en   = busy_q;
    assign sweep_addr = cnt_q;

endmodule

`default_nettype wire

// File: rtl/param_register_file.sv
// ============================================================================
// param_register_file : parametrised multi-read-port register file with
// optional zero register, write bypass and hardware clear sweep.
// Revision: 1.0
// ============================================================================
`default_nettype none

module param_register_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              sweep_en;
    logic [ADDR_W-1:0] sweep_addr;
    logic              wr_acc;
    logic              wr_store;

    reg_file_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .sweep_en   (sweep_en),
        .sweep_addr (sweep_addr)
    );

    assign wr_ready = !clr_busy;
    assign wr_acc   = wr_en && wr_ready;
    // Writes to a hardwired zero entry are accepted but never stored.
    assign wr_store = wr_acc && !(ZERO_REG && (wr_addr == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (sweep_en) begin
            mem_q[sweep_addr] <= '0;
        end else if (wr_store) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            data = mem_q[addr];
            if (ZERO_REG && (addr == '0)) begin
                data = '0;
            end else if (BYPASS && wr_acc && (wr_addr == addr)) begin
                data = wr_data;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
    end

endmodule

`default_nettype wire

// File: tb/tb_param_register_file.sv
// ============================================================================
// tb_param_register_file : directed scoreboard bench for three configurations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_param_register_file;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Default configuration: ZERO_REG=1, BYPASS=1
    logic        a_wr_en = 0, a_clr_req = 0;
    logic [3:0]  a_wr_addr = 0;
    logic [7:0]  a_wr_data = 0;
    logic [7:0]  a_rd_addr = 0;
    logic [15:0] a_rd_data;
    logic        a_wr_ready, a_clr_busy, a_clr_done;

    // ZERO_REG=0, BYPASS=0
    logic        b_wr_en = 0, b_clr_req = 0;
    logic [3:0]  b_wr_addr = 0;
    logic [7:0]  b_wr_data = 0;
    logic [7:0]  b_rd_addr = 0;
    logic [15:0] b_rd_data;
    logic        b_wr_ready, b_clr_busy, b_clr_done;

    // Wide configuration: DATA_W=16, ADDR_W=5, NUM_RD=4
    logic        c_wr_en = 0, c_clr_req = 0;
    logic [4:0]  c_wr_addr = 0;
    logic [15:0] c_wr_data = 0;
    logic [19:0] c_rd_addr = 0;
    logic [63:0] c_rd_data;
    logic        c_wr_ready, c_clr_busy, c_clr_done;

    param_register_file #(.DATA_W(8), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .wr_ready(a_wr_ready), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .clr_req(a_clr_req), .clr_busy(a_clr_busy), .clr_done(a_clr_done));

    param_register_file #(.DATA_W(8), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .wr_ready(b_wr_ready), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .clr_req(b_clr_req), .clr_busy(b_clr_busy), .clr_done(b_clr_done));

    param_register_file #(.DATA_W(16), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_c (
        .clk(clk), .rst(rst), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .wr_ready(c_wr_ready), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
        .clr_req(c_clr_req), .clr_busy(c_clr_busy), .clr_done(c_clr_done));

    typedef struct {
        string       tag;
        logic [63:0] v;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [63:0] obs);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty: observed %0h with no expected value", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                fails++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Pulses clr_req on one DUT and measures busy length and done position.
    task automatic sweep_measure(input bit use_c, input int len, input string tag);
        int nb;
        int nd;
        int di;
        nb = 0;
        nd = 0;
        di = -1;
        push({tag, "_busy_len"}, 64'(len));
        push({tag, "_done_cnt"}, 64'd1);
        push({tag, "_done_idx"}, 64'(len - 1));
        next();
        if (use_c) c_clr_req = 1'b1; else a_clr_req = 1'b1;
        next();
        a_clr_req = 1'b0;
        c_clr_req = 1'b0;
        for (int j = 0; j < len + 8; j++) begin
            #3;
            if (use_c ? c_clr_busy : a_clr_busy) nb++;
            if (use_c ? c_clr_done : a_clr_done) begin
                nd++;
                di = j;
            end
            next();
        end
        chk(64'(nb));
        chk(64'(nd));
        chk(64'(di));
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        for (int i = 0; i < 16; i++) begin
            a_rd_addr = {4'(i), 4'(i)};
            #1;
            push("rst_rd0", 64'd0);
            push("rst_rd1", 64'd0);
            chk(a_rd_data[7:0]);
            chk(a_rd_data[15:8]);
        end
        push("rst_busy", 64'd0);  chk(a_clr_busy);
        push("rst_done", 64'd0);  chk(a_clr_done);
        push("rst_ready", 64'd1); chk(a_wr_ready);
        push("rst_c_rd", 64'd0);  chk(c_rd_data);
        next();
        rst = 1'b0;

        // Same-cycle bypass versus stored-only read
        next();
        a_wr_en = 1; a_wr_addr = 4'd3; a_wr_data = 8'hA5; a_rd_addr = {4'd0, 4'd3};
        b_wr_en = 1; b_wr_addr = 4'd3; b_wr_data = 8'hA5; b_rd_addr = {4'd0, 4'd3};
        push("byp_same", 64'hA5);
        push("nobyp_same", 64'h00);
        #3;
        chk(a_rd_data[7:0]);
        chk(b_rd_data[7:0]);
        next();
        a_wr_en = 0; b_wr_en = 0;
        push("byp_next", 64'hA5);
        push("nobyp_next", 64'hA5);
        #3;
        chk(a_rd_data[7:0]);
        chk(b_rd_data[7:0]);

        // Writes to entry 0
        next();
        a_wr_en = 1; a_wr_addr = 4'd0; a_wr_data = 8'hFF; a_rd_addr = 8'h00;
        b_wr_en = 1; b_wr_addr = 4'd0; b_wr_data = 8'hFF; b_rd_addr = 8'h00;
        push("zero_ready", 64'd1);
        push("zero_rd0_same", 64'd0);
        push("zero_rd1_same", 64'd0);
        push("nozero_same", 64'd0);
        #3;
        chk(a_wr_ready);
        chk(a_rd_data[7:0]);
        chk(a_rd_data[15:8]);
        chk(b_rd_data[7:0]);
        next();
        a_wr_en = 0; b_wr_en = 0;
        push("zero_rd0_next", 64'd0);
        push("nozero_next", 64'hFF);
        #3;
        chk(a_rd_data[7:0]);
        chk(b_rd_data[7:0]);

        // Fill entries 1..15 with their own address
        for (int i = 1; i < 16; i++) begin
            next();
            a_wr_en = 1; a_wr_addr = 4'(i); a_wr_data = 8'(i);
        end
        next();
        a_wr_en = 0;
        a_clr_req = 1;
        a_rd_addr = {4'd0, 4'd15};
        push("req_cycle_busy", 64'd0);
        #3;
        chk(a_clr_busy);

        // Sweep: addr 15 holds until the last cycle, swept entries read 0
        for (int i = 0; i < 16; i++) begin
            next();
            a_clr_req = (i == 8);
            a_wr_en   = (i == 5);
            a_wr_addr = 4'd5;
            a_wr_data = 8'h77;
            if (i == 0) begin
                a_rd_addr = {4'd1, 4'd15};
                push("sw_rd1", 64'd1);
            end else if (i == 5) begin
                a_rd_addr = {4'd5, 4'd15};
                push("sw_rd1_nobyp", 64'd5);
            end else begin
                a_rd_addr = {4'(i - 1), 4'd15};
                push("sw_rd1_swept", 64'd0);
            end
            push("sw_rd0_addr15", 64'h0F);
            push("sw_busy", 64'd1);
            push("sw_done", (i == 15) ? 64'd1 : 64'd0);
            push("sw_ready", 64'd0);
            #3;
            chk(a_rd_data[15:8]);
            chk(a_rd_data[7:0]);
            chk(a_clr_busy);
            chk(a_clr_done);
            chk(a_wr_ready);
        end
        next();
        a_wr_en = 0; a_clr_req = 0;
        a_rd_addr = {4'd5, 4'd15};
        push("post_busy", 64'd0);
        push("post_done", 64'd0);
        push("post_ready", 64'd1);
        push("post_addr15", 64'd0);
        push("post_addr5_dropped", 64'd0);
        #3;
        chk(a_clr_busy);
        chk(a_clr_done);
        chk(a_wr_ready);
        chk(a_rd_data[7:0]);
        chk(a_rd_data[15:8]);
        next();
        push("post_no_restart", 64'd0);
        #3;
        chk(a_clr_busy);

        // Reset in the middle of a sweep
        next();
        a_wr_en = 1; a_wr_addr = 4'd9; a_wr_data = 8'h99;
        next();
        a_wr_en = 0; a_clr_req = 1;
        for (int i = 0; i < 7; i++) begin
            next();
            a_clr_req = 0;
            push("mid_busy", 64'd1);
            #3;
            chk(a_clr_busy);
        end
        next();
        a_rd_addr = {4'd15, 4'd9};
        push("mid_unswept9", 64'h99);
        #0;
        chk(a_rd_data[7:0]);
        #1 rst = 1'b1;
        #1;
        push("mid_rst_busy", 64'd0);
        push("mid_rst_done", 64'd0);
        push("mid_rst_ready", 64'd1);
        push("mid_rst_rd9", 64'd0);
        push("mid_rst_rd15", 64'd0);
        chk(a_clr_busy);
        chk(a_clr_done);
        chk(a_wr_ready);
        chk(a_rd_data[7:0]);
        chk(a_rd_data[15:8]);
        next();
        next();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push("after_rst_busy", 64'd0);
            push("after_rst_done", 64'd0);
            #3;
            chk(a_clr_busy);
            chk(a_clr_done);
            next();
        end
        sweep_measure(1'b0, 16, "a_sweep");

        // Wide configuration
        next();
        c_wr_en = 1; c_wr_addr = 5'd31; c_wr_data = 16'h1234;
        c_rd_addr = {5'd31, 5'd31, 5'd31, 5'd31};
        push("c_byp_all", 64'h1234_1234_1234_1234);
        #3;
        chk(c_rd_data);
        next();
        c_wr_en = 0;
        push("c_stored_all", 64'h1234_1234_1234_1234);
        #3;
        chk(c_rd_data);
        sweep_measure(1'b1, 32, "c_sweep");
        push("c_after_sweep", 64'd0);
        #3;
        chk(c_rd_data);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
